// File: rtl/aes_hpc_stream_ctrl.sv
// Stream/reseed controller between the SVRS ports and the masked AES core + PRNG.
// Credit-based admission keeps the core from ever stalling on a full ciphertext buffer.
module aes_hpc_stream_ctrl #(
    parameter int unsigned d            = 2,
    parameter int unsigned OUT_DEPTH    = 2,
    parameter int unsigned RESEED_LIMIT = 0,
    parameter int unsigned CNT_W        = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [128*d-1:0]     in_shares_plaintext,
    input  logic [128*d-1:0]     in_shares_key,
    input  logic                 in_key_reuse,
    input  logic                 in_seed_valid,
    output logic                 in_seed_ready,
    input  logic [79:0]          in_seed,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [128*d-1:0]     out_shares_ciphertext,
    output logic                 core_valid_in,
    input  logic                 core_in_ready,
    output logic [128*d-1:0]     core_plaintext,
    output logic [128*d-1:0]     core_key,
    input  logic                 core_busy,
    input  logic                 core_cipher_valid,
    output logic                 core_out_ready,
    input  logic [128*d-1:0]     core_ciphertext,
    output logic                 prng_start_reseed,
    output logic [79:0]          prng_seed,
    input  logic                 prng_out_valid,
    input  logic                 prng_busy,
    output logic                 reseed_needed,
    output logic [CNT_W-1:0]     enc_count
);

    localparam int unsigned W    = 128 * d;
    localparam int unsigned OccW = $clog2(OUT_DEPTH + 1);
    localparam int unsigned PtrW = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;

    localparam logic [OccW-1:0]  DepthCnt = OccW'(OUT_DEPTH);
    localparam logic [OccW:0]    DepthOcc = {1'b0, DepthCnt};
    localparam logic [OccW-1:0]  OccOne   = OccW'(1);
    localparam logic [PtrW-1:0]  PtrOne   = PtrW'(1);
    localparam logic [PtrW-1:0]  LastPtr  = PtrW'(OUT_DEPTH - 1);
    localparam logic [CNT_W-1:0] CntOne   = CNT_W'(1);
    localparam logic [CNT_W-1:0] Limit    = CNT_W'(RESEED_LIMIT);

    typedef enum logic [1:0] {StNoSeed, StReseed, StReady, StExhausted} state_e;

    state_e           state_q, state_d;
    logic [OccW-1:0]  count_q, count_d;
    logic [OccW-1:0]  inflight_q, inflight_d;
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [W-1:0]     buf_q [OUT_DEPTH];
    logic [W-1:0]     key_q;
    logic             key_held_q;
    logic [CNT_W-1:0] since_q, since_d;
    logic [CNT_W-1:0] enc_count_q, enc_count_d;
    logic             prev_busy_q;

    logic [OccW:0]    occupancy;
    logic             admit;
    logic             accept;
    logic             use_held;
    logic             wr_en;
    logic             rd_en;

    // Credits: buffered entries plus blocks still inside the core must fit in the buffer.
    assign occupancy = {1'b0, count_q} + {1'b0, inflight_q};
    assign admit     = (state_q == StReady) & prng_out_valid & (occupancy < DepthOcc);

    assign core_valid_in  = in_valid & admit;
    assign in_ready       = core_in_ready & admit;
    assign accept         = in_valid & in_ready;
    assign use_held       = in_key_reuse & key_held_q;
    assign core_key       = use_held ? key_q : in_shares_key;
    assign core_plaintext = in_shares_plaintext;

    // A pending block has priority over a seed; reseed only with the core fully drained.
    assign prng_start_reseed = in_seed_valid & ~core_busy & (inflight_q == '0)
                             & ~(in_valid & admit) & (state_q != StReseed);
    assign prng_seed         = in_seed;
    assign in_seed_ready     = prng_busy & ~prev_busy_q;
    assign reseed_needed     = (state_q == StNoSeed) | (state_q == StExhausted);

    assign core_out_ready        = 1'b1;
    assign wr_en                 = core_cipher_valid;
    assign out_valid             = (count_q != '0);
    assign rd_en                 = out_valid & out_ready;
    assign out_shares_ciphertext = buf_q[rd_ptr_q];
    assign enc_count             = enc_count_q;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StNoSeed: begin
                if (prng_start_reseed) state_d = StReseed;
            end
            StReseed: begin
                if (prev_busy_q & ~prng_busy) state_d = StReady;
            end
            StReady: begin
                if (prng_start_reseed) begin
                    state_d = StReseed;
                end else if (accept && (RESEED_LIMIT != 0) && (since_q + CntOne == Limit)) begin
                    state_d = StExhausted;
                end
            end
            StExhausted: begin
                if (prng_start_reseed) state_d = StReseed;
            end
            default: state_d = StNoSeed;
        endcase
    end

    always_comb begin
        inflight_d  = inflight_q;
        count_d     = count_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        since_d     = since_q;
        enc_count_d = enc_count_q;

        if (accept && !wr_en) inflight_d = inflight_q + OccOne;
        if (!accept && wr_en) inflight_d = inflight_q - OccOne;

        if (wr_en && !rd_en) count_d = count_q + OccOne;
        if (!wr_en && rd_en) count_d = count_q - OccOne;

        if (wr_en) wr_ptr_d = (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + PtrOne;
        if (rd_en) rd_ptr_d = (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + PtrOne;

        if (prng_start_reseed) begin
            since_d = '0;
        end else if (accept && (since_q != '1)) begin
            since_d = since_q + CntOne;
        end

        if (accept && (enc_count_q != '1)) enc_count_d = enc_count_q + CntOne;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StNoSeed;
            count_q     <= '0;
            inflight_q  <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            key_q       <= '0;
            key_held_q  <= 1'b0;
            since_q     <= '0;
            enc_count_q <= '0;
            prev_busy_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            inflight_q  <= inflight_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            since_q     <= since_d;
            enc_count_q <= enc_count_d;
            prev_busy_q <= prng_busy;
            if (accept && !use_held) begin
                key_q      <= in_shares_key;
                key_held_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) buf_q[wr_ptr_q] <= core_ciphertext;
    end

    inflight_bound_a: assert property (@(posedge clk) disable iff (!rst_n)
        inflight_q <= DepthCnt);
    count_bound_a: assert property (@(posedge clk) disable iff (!rst_n)
        count_q <= DepthCnt);

endmodule

// File: tb/tb_aes_hpc_stream_ctrl.sv
// Randomised bench: fake core and PRNG, a block-level reference model, and a ciphertext scoreboard.
module tb_aes_hpc_stream_ctrl;

    localparam int unsigned D     = 2;
    localparam int unsigned DEPTH = 2;
    localparam int unsigned LIMIT = 3;
    localparam int unsigned CW    = 32;
    localparam int unsigned W     = 128 * D;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid, in_ready, in_key_reuse;
    logic [W-1:0]  in_shares_plaintext, in_shares_key;
    logic          in_seed_valid, in_seed_ready;
    logic [79:0]   in_seed, prng_seed;
    logic          out_valid, out_ready;
    logic [W-1:0]  out_shares_ciphertext;
    logic          core_valid_in, core_in_ready, core_busy, core_cipher_valid, core_out_ready;
    logic [W-1:0]  core_plaintext, core_key, core_ciphertext;
    logic          prng_start_reseed, prng_out_valid, prng_busy, reseed_needed;
    logic [CW-1:0] enc_count;

    aes_hpc_stream_ctrl #(
        .d            (D),
        .OUT_DEPTH    (DEPTH),
        .RESEED_LIMIT (LIMIT),
        .CNT_W        (CW)
    ) dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .in_valid              (in_valid),
        .in_ready              (in_ready),
        .in_shares_plaintext   (in_shares_plaintext),
        .in_shares_key         (in_shares_key),
        .in_key_reuse          (in_key_reuse),
        .in_seed_valid         (in_seed_valid),
        .in_seed_ready         (in_seed_ready),
        .in_seed               (in_seed),
        .out_valid             (out_valid),
        .out_ready             (out_ready),
        .out_shares_ciphertext (out_shares_ciphertext),
        .core_valid_in         (core_valid_in),
        .core_in_ready         (core_in_ready),
        .core_plaintext        (core_plaintext),
        .core_key              (core_key),
        .core_busy             (core_busy),
        .core_cipher_valid     (core_cipher_valid),
        .core_out_ready        (core_out_ready),
        .core_ciphertext       (core_ciphertext),
        .prng_start_reseed     (prng_start_reseed),
        .prng_seed             (prng_seed),
        .prng_out_valid        (prng_out_valid),
        .prng_busy             (prng_busy),
        .reseed_needed         (reseed_needed),
        .enc_count             (enc_count)
    );

    always #5 clk = ~clk;

    int unsigned  n_cmp = 0;
    int unsigned  n_err = 0;
    logic [W-1:0] sb_q[$];

    // Block-level model: seeded/reseeding flags, blocks per seed, open blocks, held key.
    bit           m_seeded, m_reseeding, m_end_pending, m_key_held;
    logic [W-1:0] m_key;
    int unsigned  m_open, m_inflight, m_buf, m_since, m_enc;
    // Fake PRNG and fake core.
    bit           p_busy, p_prev, c_busy;
    int unsigned  p_cnt, c_cnt;
    logic [W-1:0] c_pt, c_k;
    // Events observed at the last sample point.
    bit           s_acc, s_fire, s_pop, s_core_out, s_start, s_seed_rdy;
    logic [W-1:0] s_core_pt, s_core_key;

    bit allow_in   = 1'b1;
    bit allow_seed = 1'b1;
    int out_mode   = 0;

    function automatic logic [W-1:0] enc(input logic [W-1:0] p, input logic [W-1:0] k);
        return p ^ {k[W-9:0], k[W-1:W-8]};
    endfunction

    function automatic logic [W-1:0] rand_w();
        logic [W-1:0] r;
        for (int i = 0; i < W / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic check_bit(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    task automatic check_word(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_seeded = 0; m_reseeding = 0; m_end_pending = 0; m_key_held = 0; m_key = '0;
        m_open = 0; m_inflight = 0; m_buf = 0; m_since = 0; m_enc = 0;
        p_busy = 0; p_prev = 0; p_cnt = 0; c_busy = 0; c_cnt = 0; c_pt = '0; c_k = '0;
        s_acc = 0; s_fire = 0; s_pop = 0; s_core_out = 0; s_start = 0; s_seed_rdy = 0;
        sb_q.delete();
    endtask

    task automatic drive_idle();
        in_valid = 0; in_key_reuse = 0; in_shares_plaintext = '0; in_shares_key = '0;
        in_seed_valid = 0; in_seed = '0; out_ready = 0;
        core_in_ready = 1; core_busy = 0; core_cipher_valid = 0; core_ciphertext = '0;
        prng_busy = 0; prng_out_valid = 1;
    endtask

    function automatic bit model_needs_seed();
        return !m_reseeding && (!m_seeded || (LIMIT != 0 && m_since >= LIMIT));
    endfunction

    task automatic sample_check();
        bit admit_m;
        bit exp_start;
        admit_m = m_seeded && !m_reseeding && (LIMIT == 0 || m_since < LIMIT)
                  && prng_out_valid && (m_open < DEPTH);
        exp_start = in_seed_valid && !core_busy && (m_inflight == 0)
                    && !(in_valid && admit_m) && !m_reseeding;
        check_bit("in_ready", in_ready, admit_m && core_in_ready);
        check_bit("core_valid_in", core_valid_in, admit_m && in_valid);
        check_bit("out_valid", out_valid, m_buf != 0);
        check_bit("reseed_needed", reseed_needed, model_needs_seed());
        check_bit("prng_start_reseed", prng_start_reseed, exp_start);
        check_bit("in_seed_ready", in_seed_ready, p_busy && !p_prev);
        check_bit("core_out_ready", core_out_ready, 1'b1);
        check_word("enc_count", W'(enc_count), W'(m_enc));
        if (prng_start_reseed) check_word("prng_seed", W'(prng_seed), W'(in_seed));

        s_acc      = in_valid && in_ready;
        s_fire     = core_valid_in && core_in_ready;
        s_pop      = out_valid && out_ready;
        s_core_out = core_cipher_valid;
        s_start    = prng_start_reseed;
        s_seed_rdy = in_seed_ready;
        s_core_pt  = core_plaintext;
        s_core_key = core_key;
        if (s_acc) begin
            logic [W-1:0] k;
            bit held;
            held = in_key_reuse && m_key_held;
            k = held ? m_key : in_shares_key;
            if (!held) begin
                m_key = in_shares_key;
                m_key_held = 1;
            end
            sb_q.push_back(enc(in_shares_plaintext, k));
        end
    endtask

    task automatic update_drive();
        if (s_acc) begin m_open++; m_inflight++; m_since++; m_enc++; end
        if (s_core_out) begin m_inflight--; m_buf++; end
        if (s_pop) begin m_open--; m_buf--; end
        if (m_end_pending) begin m_reseeding = 0; m_seeded = 1; m_end_pending = 0; end
        if (s_start) begin m_reseeding = 1; m_since = 0; end

        p_prev = p_busy;
        if (s_start) begin
            p_busy = 1; p_cnt = $urandom_range(3, 1);
        end else if (p_busy) begin
            if (p_cnt == 0) begin p_busy = 0; m_end_pending = 1; end
            else p_cnt--;
        end
        prng_busy      = p_busy;
        prng_out_valid = !p_busy && ($urandom_range(7) != 0);

        core_cipher_valid = 0;
        if (s_fire) begin
            c_busy = 1; c_cnt = $urandom_range(3); c_pt = s_core_pt; c_k = s_core_key;
        end else if (c_busy) begin
            if (c_cnt == 0) begin
                core_cipher_valid = 1; core_ciphertext = enc(c_pt, c_k); c_busy = 0;
            end else c_cnt--;
        end
        core_busy     = c_busy;
        core_in_ready = !c_busy;

        if (!in_valid || s_acc) begin
            in_valid            = allow_in && ($urandom_range(3) != 0);
            in_shares_plaintext = rand_w();
            in_shares_key       = rand_w();
            in_key_reuse        = $urandom_range(1);
        end else if (!allow_in) in_valid = 0;

        if (in_seed_valid && s_seed_rdy) in_seed_valid = 0;
        else if (!in_seed_valid && allow_seed && ($urandom_range(23) == 0 || model_needs_seed())) begin
            in_seed_valid = 1;
            in_seed       = {$urandom, $urandom, 16'($urandom)};
        end

        case (out_mode)
            1:       out_ready = 0;
            2:       out_ready = 1;
            default: out_ready = ($urandom_range(3) != 0);
        endcase
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            sample_check();
            @(posedge clk);
            #1;
            update_drive();
        end
    endtask

    task automatic async_reset();
        @(negedge clk);
        #2;
        rst_n = 0;
        #1;
        check_bit("arst_out_valid", out_valid, 1'b0);
        check_bit("arst_in_ready", in_ready, 1'b0);
        check_bit("arst_reseed_needed", reseed_needed, 1'b1);
        check_word("arst_enc_count", W'(enc_count), '0);
        model_reset();
        drive_idle();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1;
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL ciphertext at %0t: got %0h expected none", $time,
                         out_shares_ciphertext);
            end else begin
                check_word("ciphertext", out_shares_ciphertext, sb_q.pop_front());
            end
        end
    end

    initial begin
        int k;
        model_reset();
        drive_idle();
        rst_n = 0;
        @(posedge clk);
        #1;
        check_bit("rst_out_valid", out_valid, 1'b0);
        check_bit("rst_in_ready", in_ready, 1'b0);
        check_bit("rst_in_seed_ready", in_seed_ready, 1'b0);
        check_bit("rst_start_reseed", prng_start_reseed, 1'b0);
        check_bit("rst_reseed_needed", reseed_needed, 1'b1);
        check_word("rst_enc_count", W'(enc_count), '0);
        @(negedge clk);
        rst_n = 1;

        // Unseeded: a waiting block must not be admitted.
        allow_seed = 0;
        in_valid = 1;
        in_shares_plaintext = rand_w();
        in_shares_key = rand_w();
        run(8);
        allow_seed = 1;
        run(2000);

        // Stall the output so the buffer fills, then reset with it full.
        out_mode = 1;
        run(60);
        async_reset();

        out_mode = 0;
        run(1500);
        k = 0;
        while (!m_reseeding && k < 500) begin
            run(1);
            k++;
        end
        if (!m_reseeding) begin
            n_cmp++;
            n_err++;
            $display("FAIL reseed_wait: got no reseed expected one within 500 cycles");
        end
        async_reset();

        run(1500);
        allow_in = 0;
        out_mode = 2;
        run(40);
        check_word("drain_left", W'(sb_q.size()), '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
